// File: rtl/terminal_hex_dumper.sv
// terminal_hex_dumper
// Snapshots NUM_WORDS 32-bit debug words on a start request and renders them
// as uppercase hex text (8 nibbles MSB first plus a separator per word) into a
// terminal text memory, one character per accepted write.
// Optional build macro HEXDUMP_CHANGE_MARK_EN: keeps the previous frame's
// snapshot and uses '*' as the separator of every word that changed.
module terminal_hex_dumper #(
    parameter int NUM_WORDS = 32,
    parameter int COLS      = 4,
    parameter int ROW_CHARS = 80,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_WORDS*32-1:0] words,
    input  logic                    terminal_ready,
    output logic [ADDR_W-1:0]       terminal_addr,
    output logic                    terminal_write,
    output logic [7:0]              terminal_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, SNAP, EMIT} state_t;

    state_t                  state_q;
    logic [NUM_WORDS*32-1:0] snap_q;
`ifdef HEXDUMP_CHANGE_MARK_EN
    logic [NUM_WORDS*32-1:0] prev_q;
    logic [31:0]             prev_word_d;
`endif
    logic [WIDX_W-1:0]       word_q, word_d;
    logic [3:0]              nib_q, nib_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ADDR_W-1:0]       row_base_q, row_base_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              data_q, char_d;
    logic                    write_q, busy_q, done_q;
    logic                    last_char_d;
    logic [31:0]             cur_word_d;
    logic [3:0]              cur_nib_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // Next character position (taken on acceptance) and the character it shows.
    // Within a row consecutive words are contiguous, so the address simply
    // increments; only a column wrap jumps to the next row base.
    always_comb begin
        last_char_d = (nib_q == 4'd8) && (word_q == WIDX_W'(NUM_WORDS - 1));
        word_d      = word_q;
        nib_d       = nib_q + 4'd1;
        col_d       = col_q;
        row_base_d  = row_base_q;
        addr_d      = addr_q + ADDR_W'(1);
        if (nib_q == 4'd8) begin
            nib_d = 4'd0;
            if (!last_char_d) begin
                word_d = word_q + WIDX_W'(1);
            end
            if (col_q == COL_W'(COLS - 1)) begin
                col_d      = '0;
                row_base_d = row_base_q + ADDR_W'(ROW_CHARS);
                addr_d     = row_base_d;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // In SNAP the first character comes straight from the words being latched.
        if (state_q == SNAP) begin
            cur_word_d = words[31:0];
            cur_nib_d  = 4'd0;
        end else begin
            cur_word_d = snap_q[32*int'(word_d) +: 32];
            cur_nib_d  = nib_d;
        end

`ifdef HEXDUMP_CHANGE_MARK_EN
        prev_word_d = prev_q[32*int'(word_d) +: 32];
`endif
        if (cur_nib_d == 4'd8) begin
`ifdef HEXDUMP_CHANGE_MARK_EN
            char_d = (cur_word_d != prev_word_d) ? 8'h2A : 8'h20;
`else
            char_d = 8'h20;
`endif
        end else begin
            char_d = hex_char(4'(cur_word_d >> (5'd28 - {cur_nib_d[2:0], 2'b00})));
        end
    end

    // Frame FSM with registered terminal outputs and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            snap_q     <= '0;
`ifdef HEXDUMP_CHANGE_MARK_EN
            prev_q     <= '0;
`endif
            word_q     <= '0;
            nib_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= SNAP;
                    end
                end
                SNAP: begin
`ifdef HEXDUMP_CHANGE_MARK_EN
                    prev_q     <= snap_q;
`endif
                    snap_q     <= words;
                    word_q     <= '0;
                    nib_q      <= '0;
                    col_q      <= '0;
                    row_base_q <= ADDR_W'(BASE_ADDR);
                    addr_q     <= ADDR_W'(BASE_ADDR);
                    data_q     <= char_d;
                    write_q    <= 1'b1;
                    state_q    <= EMIT;
                end
                EMIT: begin
                    if (write_q && terminal_ready) begin
                        if (last_char_d) begin
                            write_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            word_q     <= word_d;
                            nib_q      <= nib_d;
                            col_q      <= col_d;
                            row_base_q <= row_base_d;
                            addr_q     <= addr_d;
                            data_q     <= char_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign terminal_addr  = addr_q;
    assign terminal_write = write_q;
    assign terminal_data  = data_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;

endmodule
